// File: rtl/ram_fifo_stream_ctrl.sv
// Streaming FIFO controller for a simple dual-port RAM (sync write, one-cycle
// read latency) with a 2-entry first-word-fall-through output buffer.
module ram_fifo_stream_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [DATA_WIDTH-1:0] ram_d,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [ADDR_WIDTH+1:0] count
);

  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam int unsigned CW = ADDR_WIDTH + 2;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [PW-1:0]         wr_ptr, iss_ptr, rd_ptr;
  logic [PW-1:0]         wr_nxt, iss_nxt, rd_nxt;
  logic [PW-1:0]         ram_occ_nxt;
  logic                  pend;
  logic [1:0]            buf_cnt, buf_cnt_nxt, buf_after_pop;
  logic [DATA_WIDTH-1:0] buf_head, buf_skid, head_nxt, skid_nxt;
  logic [2:0]            buf_demand;
  logic                  push, pop, issue;
  logic [CW-1:0]         count_nxt;

  // RAM-facing strobes and addresses are direct decodes of the pointers
  assign push       = s_valid & s_ready;
  assign pop        = m_valid & m_ready;
  assign ram_we     = push;
  assign ram_w_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_d      = s_data;
  assign ram_r_addr = iss_ptr[ADDR_WIDTH-1:0];
  assign m_valid    = (buf_cnt != 2'd0);
  assign m_data     = buf_head;

  // Issue decision, pointer/occupancy next state and output-buffer steering
  always_comb begin
    buf_demand    = 3'({1'b0, buf_cnt}) + 3'(pend) - 3'(pop);
    issue         = (wr_ptr != iss_ptr) && (buf_demand <= 3'd1);
    wr_nxt        = wr_ptr + PW'(push);
    iss_nxt       = iss_ptr + PW'(issue);
    rd_nxt        = rd_ptr + PW'(pend);
    buf_after_pop = buf_cnt - 2'(pop);
    buf_cnt_nxt   = buf_after_pop + 2'(pend);
    ram_occ_nxt   = wr_nxt - rd_nxt;
    count_nxt     = CW'(ram_occ_nxt) + CW'(buf_cnt_nxt);
    head_nxt      = buf_head;
    skid_nxt      = buf_skid;
    if (pop) begin
      head_nxt = buf_skid;
    end
    if (pend) begin
      if (buf_after_pop == 2'd0) begin
        head_nxt = ram_q;
      end else begin
        skid_nxt = ram_q;
      end
    end
  end

  // Pointer, pending-read, buffer and flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      iss_ptr  <= '0;
      rd_ptr   <= '0;
      pend     <= 1'b0;
      buf_cnt  <= 2'd0;
      buf_head <= '0;
      buf_skid <= '0;
      s_ready  <= 1'b0;
      count    <= '0;
    end else begin
      wr_ptr   <= wr_nxt;
      iss_ptr  <= iss_nxt;
      rd_ptr   <= rd_nxt;
      pend     <= issue;
      buf_cnt  <= buf_cnt_nxt;
      buf_head <= head_nxt;
      buf_skid <= skid_nxt;
      s_ready  <= (ram_occ_nxt != DEPTH);
      count    <= count_nxt;
    end
  end

endmodule

// File: tb/tb_ram_fifo_stream_ctrl.sv
// Bench for ram_fifo_stream_ctrl with a 4-word RAM model and a queue scoreboard.
module tb_ram_fifo_stream_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;
  localparam int unsigned CAP = (1 << AW) + 2;

  logic          clk, reset_n;
  logic          s_valid, s_ready, m_valid, m_ready;
  logic [DW-1:0] s_data, m_data, ram_d, ram_q;
  logic          ram_we;
  logic [AW-1:0] ram_w_addr, ram_r_addr;
  logic [AW+1:0] count;
  logic [DW-1:0] mem [4];

  ram_fifo_stream_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ram_we(ram_we), .ram_w_addr(ram_w_addr), .ram_d(ram_d),
    .ram_r_addr(ram_r_addr), .ram_q(ram_q), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: sync write, address latched on the edge, data out one cycle later
  always @(posedge clk) begin
    if (ram_we) mem[ram_w_addr] <= ram_d;
    ram_q <= mem[ram_r_addr];
  end

  typedef struct {
    logic          sv;
    logic [DW-1:0] d;
    logic          mr;
    logic          e_we;
    logic          e_mv;
    logic [DW-1:0] e_md;
    int            e_cnt;
    logic          e_rdy;
  } vec_t;

  int            n_vec = 0;
  int            n_bad = 0;
  logic [DW-1:0] q[$];
  int            wr_total = 0;
  int            cyc = 0;
  bit            acc_f, pop_f;
  int            npop = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock cycle: sample at negedge, check against the queue model, advance
  task automatic step();
    @(negedge clk);
    acc_f = s_valid && s_ready;
    pop_f = m_valid && m_ready;
    chk("count", count, q.size());
    chk("count_max", (count <= CAP), 1);
    chk("ram_we", ram_we, acc_f);
    if (acc_f) begin
      chk("ram_w_addr", ram_w_addr, wr_total % 4);
      chk("ram_d", ram_d, s_data);
    end
    if (pop_f) begin
      if (q.size() == 0) begin
        chk("pop_nonempty", 0, 1);
      end else begin
        chk("m_data", m_data, q[0]);
        void'(q.pop_front());
      end
      npop++;
    end
    if (acc_f) begin
      q.push_back(s_data);
      wr_total++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() > 0; i++) step();
    step();
    chk("drain_empty", q.size(), 0);
  endtask

  vec_t tbl[5];

  initial begin
    int sent, first_acc, first_pop, last_pop, c0, pop_cyc, acc_cyc, t0;

    tbl[0] = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b1};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1, 1'b1};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 1, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1};

    // Reset state
    reset_n = 1'b0; s_valid = 1'b1; s_data = 8'h00; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_ram_we", ram_we, 0);
    s_valid = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single word latency, table driven
    for (int i = 0; i < 5; i++) begin
      s_valid = tbl[i].sv; s_data = tbl[i].d; m_ready = tbl[i].mr;
      @(negedge clk);
      chk($sformatf("t%0d_ram_we", i), ram_we, tbl[i].e_we);
      chk($sformatf("t%0d_m_valid", i), m_valid, tbl[i].e_mv);
      if (tbl[i].e_mv) chk($sformatf("t%0d_m_data", i), m_data, tbl[i].e_md);
      chk($sformatf("t%0d_count", i), count, tbl[i].e_cnt);
      chk($sformatf("t%0d_s_ready", i), s_ready, tbl[i].e_rdy);
      if (tbl[i].e_we) chk("t_w_addr", ram_w_addr, 0);
      if (tbl[i].sv && s_ready) wr_total++;
      @(posedge clk); #1;
      cyc++;
    end

    // Fill with m_ready=0: 6 words fit, then release and drain in order
    sent = 0; m_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      s_valid = 1'b1; s_data = DW'(sent);
      step();
      if (acc_f) sent++;
    end
    chk("fill_accepted", sent, CAP);
    chk("fill_count", count, CAP);
    chk("fill_s_ready", s_ready, 0);
    m_ready = 1'b1;
    for (int i = 0; i < 60 && sent < 10; i++) begin
      s_valid = 1'b1; s_data = DW'(sent);
      step();
      if (acc_f) sent++;
    end
    chk("fill_rest_sent", sent, 10);
    drain();

    // Continuous streaming, 1000 words
    sent = 0; npop = 0; first_acc = -1; first_pop = -1; last_pop = -1;
    m_ready = 1'b1;
    for (int i = 0; i < 1200 && npop < 1000; i++) begin
      s_valid = (sent < 1000); s_data = DW'(sent);
      t0 = cyc;
      step();
      if (acc_f) begin
        sent++;
        if (first_acc < 0) first_acc = t0;
      end
      if (pop_f) begin
        if (first_pop < 0) first_pop = t0;
        last_pop = t0;
      end
    end
    chk("stream_pops", npop, 1000);
    chk("stream_latency", first_pop - first_acc, 3);
    chk("stream_no_gaps", last_pop - first_pop, 999);
    drain();

    // Random valid/ready, 10k words
    sent = 0; npop = 0;
    for (int i = 0; i < 60000 && npop < 10000; i++) begin
      s_valid = ($urandom_range(0, 1) == 1) && (sent < 10000);
      s_data = DW'($urandom);
      m_ready = ($urandom_range(0, 1) == 1);
      step();
      if (acc_f) sent++;
    end
    chk("rand_pops", npop, 10000);
    drain();

    // Asynchronous reset mid-stream with count=5
    m_ready = 1'b0;
    for (int i = 0; i < 20 && count != 5; i++) begin
      s_valid = 1'b1; s_data = DW'($urandom);
      step();
    end
    chk("pre_reset_count", count, 5);
    s_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async_m_valid", m_valid, 0);
    chk("async_s_ready", s_ready, 0);
    chk("async_count", count, 0);
    q.delete(); wr_total = 0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_s_ready", s_ready, 1);
    s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1; npop = 0;
    c0 = cyc;
    step();
    s_valid = 1'b0;
    pop_cyc = -1;
    for (int i = 0; i < 10 && npop == 0; i++) begin
      t0 = cyc;
      step();
      if (pop_f) pop_cyc = t0;
    end
    chk("a5_latency", pop_cyc - c0, 3);

    // Full block: pop and s_valid in the same cycle
    m_ready = 1'b0; sent = 0;
    for (int i = 0; i < 20 && s_ready; i++) begin
      s_valid = 1'b1; s_data = DW'(8'h40 + sent);
      step();
      if (acc_f) sent++;
    end
    chk("full_count", count, CAP);
    chk("full_s_ready", s_ready, 0);
    s_valid = 1'b1; s_data = 8'h77; m_ready = 1'b1;
    pop_cyc = cyc;
    step();
    chk("full_pop_no_write", acc_f, 0);
    chk("full_pop_popped", pop_f, 1);
    m_ready = 1'b0;
    acc_cyc = -1;
    for (int i = 0; i < 10 && acc_cyc < 0; i++) begin
      t0 = cyc;
      step();
      if (acc_f) acc_cyc = t0;
    end
    chk("full_refill_delay", acc_cyc - pop_cyc, 2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_fifo_stream_ctrl.md
Name: ram_fifo_stream_ctrl

Overview:
- Controller and read-side prefetch stage that sits directly upstream of the simple dual-port RAM (sync write, registered read address, one-cycle read latency).
- Generates the RAM write strobe, write address and read address, and captures RAM read data.
- Turns the RAM into a valid/ready streaming FIFO whose head word is always presented ahead of demand (first-word-fall-through).
- Total capacity is 2**ADDR_WIDTH RAM words plus 2 output-buffer words.

Parameters:
DATA_WIDTH, 8, word width; must match the RAM's DATA_WIDTH
ADDR_WIDTH, 10, RAM address bits; the RAM holds 2**ADDR_WIDTH words

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
s_valid  in  1  upstream word valid
s_ready  out  1  block can accept a word
s_data  in  DATA_WIDTH  upstream word
m_valid  out  1  head word valid
m_ready  in  1  downstream consumes head word
m_data  out  DATA_WIDTH  head word
ram_we  out  1  RAM write enable
ram_w_addr  out  ADDR_WIDTH  RAM write address
ram_d  out  DATA_WIDTH  RAM write data
ram_r_addr  out  ADDR_WIDTH  RAM read address; the RAM latches it on the same edge
ram_q  in  DATA_WIDTH  RAM read data; valid the cycle after its address is presented
count  out  ADDR_WIDTH+2  total words held (RAM + in flight + output buffer)

Behaviour:
- Reset (reset_n low, asynchronous):
  - wr_ptr, iss_ptr and rd_ptr (each ADDR_WIDTH+1 bits) cleared to 0; pend=0; output buffer emptied.
  - m_valid=0, s_ready=0, ram_we=0, count=0.
  - Any reset, including mid-operation, discards all contents.
  - s_ready rises in the first cycle after reset_n deasserts.
- Pointers:
  - wr_ptr = words written to RAM.
  - iss_ptr = read addresses issued.
  - rd_ptr = RAM words captured into the output buffer. A RAM slot is freed only on capture, never on issue.
  - Pointer arithmetic is modulo 2**(ADDR_WIDTH+1); the MSB is the wrap bit.
- Write side:
  - full = (wr_ptr - rd_ptr) == 2**ADDR_WIDTH.
  - s_ready = !full (registered full flag, not combinational on s_valid).
  - ram_we = s_valid & s_ready, ram_w_addr = wr_ptr[ADDR_WIDTH-1:0], ram_d = s_data (combinational).
  - wr_ptr increments on acceptance.
- Read issue, evaluated in cycle t:
  - pop = m_valid & m_ready.
  - issue = (wr_ptr != iss_ptr) & (buf_cnt + pend - pop <= 1).
  - ram_r_addr = iss_ptr[ADDR_WIDTH-1:0] always (don't-care when not issuing).
  - On issue, iss_ptr increments and pend is set for cycle t+1.
  - A word becomes issue-eligible only in the cycle after its write; there is no same-cycle write/issue bypass.
- Capture:
  - When pend=1, ram_q is written into the 2-entry output buffer at the end of that cycle and rd_ptr increments.
  - pend is at most 1; back-to-back issues give one capture per cycle.
- Output buffer:
  - 2-entry FIFO (head + skid); m_valid = buf_cnt != 0; m_data = head entry.
  - Capture and pop may happen in the same cycle: buf_cnt holds and the head advances correctly.
  - The issue rule guarantees buffer overflow never occurs.
- Latency:
  - A word accepted in cycle t into an empty block is issued in t+1, captured at the end of t+2, and has m_valid=1 in t+3.
  - Steady-state throughput is 1 word/cycle in and out simultaneously.
- count:
  - count = (wr_ptr - rd_ptr) + pend_is_not_counted_twice + buf_cnt, i.e. RAM-resident words (including the in-flight word) + buf_cnt.
  - Registered; maximum value 2**ADDR_WIDTH+2.
- Boundaries:
  - Full and a pop in the same cycle: s_ready stays 0 that cycle and rises only after rd_ptr advances.
  - Empty: m_valid=0; m_ready is ignored.
  - Address wrap at 2**ADDR_WIDTH is seamless.

Test Plan:
- Reset, then write 0x11 in cycle 0 with m_ready=1 -> ram_we=1, ram_w_addr=0 in cycle 0; m_valid=1 with m_data=0x11 in cycle 3; count returns to 0 after the pop.
- ADDR_WIDTH=2, m_ready=0, stream 0..9 -> 6 words accepted (count=6), s_ready=0 from then on; releasing m_ready yields 0..5 in order, then the remaining words after refill.
- Continuous s_valid=1, m_ready=1, 1000 incrementing words -> after the 3-cycle fill, one output per cycle with no gaps, order preserved across multiple address wraps.
- Random s_valid/m_ready toggling (50%) for 10k words -> output sequence equals input sequence; count never exceeds 2**ADDR_WIDTH+2; no word dropped or duplicated.
- Assert reset_n low mid-stream with count=5 -> m_valid, s_ready and count go to 0 immediately (asynchronously); after release, a new word 0xA5 emerges first with 3-cycle latency.
- Full block, pop and s_valid asserted in the same cycle -> no write that cycle; the write is accepted once the freed slot is reflected in s_ready, and data integrity holds.
